// File: rtl/homegrown_watch_wb.sv
`default_nettype none
// ============================================================================
//  Module   : homegrown_watch_wb
//  Purpose  : Wishbone-classic slave implementing a 24-hour watch with a
//             programmable prescaler, an alarm comparator and an interrupt.
//  Ports    : wb_clk_i / wb_rst_ni   clock, asynchronous active-low reset
//             wbs_*                  Wishbone classic slave (32-byte window)
//             tick_o                 one-cycle pulse per watch second
//             irq_o                  registered alarm interrupt
//  Registers: 0x00 CTRL     [0] run, [1] alarm_en, [2] irq_en
//             0x04 PRESCALE [31:0]
//             0x08 TIME     [5:0] sec, [13:8] min, [20:16] hour
//             0x0C ALARM    same layout as TIME
//             0x10 STATUS   [0] alarm_flag (write 1 to clear)
//             0x14-0x1C     read as zero, writes ignored
//  Revision : 1.0  initial release
// ============================================================================
module homegrown_watch_wb #(
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter logic [31:0] PRESCALE_RST = 32'd9_999_999
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        tick_o,
    output logic        irq_o
);

    localparam logic [2:0] c_reg_ctrl     = 3'd0;
    localparam logic [2:0] c_reg_prescale = 3'd1;
    localparam logic [2:0] c_reg_time     = 3'd2;
    localparam logic [2:0] c_reg_alarm    = 3'd3;
    localparam logic [2:0] c_reg_status   = 3'd4;

    localparam logic [5:0] c_sec_max  = 6'd59;
    localparam logic [5:0] c_min_max  = 6'd59;
    localparam logic [4:0] c_hour_max = 5'd23;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic        ack_q,      ack_d;
    logic [31:0] dat_q,      dat_d;
    logic        tick_q,     tick_d;
    logic        irq_q,      irq_d;
    logic [2:0]  ctrl_q,     ctrl_d;
    logic [31:0] prescale_q, prescale_d;
    logic [31:0] cnt_q,      cnt_d;
    logic [5:0]  sec_q,      sec_d;
    logic [5:0]  min_q,      min_d;
    logic [4:0]  hour_q,     hour_d;
    logic [5:0]  asec_q,     asec_d;
    logic [5:0]  amin_q,     amin_d;
    logic [4:0]  ahour_q,    ahour_d;
    logic        flag_q,     flag_d;
    // Marks that TIME was updated on the previous edge; the alarm compare
    // is done one cycle later against the settled TIME value.
    logic        chg_q,      chg_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic        w_sel;
    logic        w_req;
    logic        w_wr;
    logic        w_rd;
    logic [2:0]  w_idx;
    logic        w_tick;
    logic        w_clr;
    logic [31:0] w_time_word;
    logic [31:0] w_alarm_word;
    logic [31:0] w_merged;

    // Byte address bits [1:0] do not affect word-wide register access.
    logic        unused_adr_bits;
    assign unused_adr_bits = ^wbs_adr_i[1:0];

    function automatic logic [31:0] pack_time(input logic [4:0] h,
                                              input logic [5:0] m,
                                              input logic [5:0] s);
        pack_time = {11'd0, h, 2'd0, m, 2'd0, s};
    endfunction

    // Byte-lane merge of write data into the current register value.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        lane_merge = res;
    endfunction

    assign w_sel = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    // While ack is high the bus is busy: forces one idle cycle between transfers.
    assign w_req = w_sel & ~ack_q;
    assign w_wr  = w_req & wbs_we_i;
    assign w_rd  = w_req & ~wbs_we_i;
    assign w_idx = wbs_adr_i[4:2];

    assign w_tick       = ctrl_q[0] & (cnt_q == prescale_q);
    assign w_time_word  = pack_time(hour_q, min_q, sec_q);
    assign w_alarm_word = pack_time(ahour_q, amin_q, asec_q);

    always_comb begin
        w_merged = 32'd0;
        case (w_idx)
            c_reg_ctrl:     w_merged = lane_merge({29'd0, ctrl_q}, wbs_dat_i, wbs_sel_i);
            c_reg_prescale: w_merged = lane_merge(prescale_q, wbs_dat_i, wbs_sel_i);
            c_reg_time:     w_merged = lane_merge(w_time_word, wbs_dat_i, wbs_sel_i);
            c_reg_alarm:    w_merged = lane_merge(w_alarm_word, wbs_dat_i, wbs_sel_i);
            default:        w_merged = 32'd0;
        endcase
    end

    assign w_clr = w_wr & (w_idx == c_reg_status) & wbs_sel_i[0] & wbs_dat_i[0];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        ack_d      = w_req;
        dat_d      = 32'd0;
        tick_d     = w_tick;
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        cnt_d      = cnt_q;
        sec_d      = sec_q;
        min_d      = min_q;
        hour_d     = hour_q;
        asec_d     = asec_q;
        amin_d     = amin_q;
        ahour_d    = ahour_q;
        chg_d      = 1'b0;
        flag_d     = flag_q;
        irq_d      = flag_q & ctrl_q[2];

        // Read data is captured with the request so it is valid with ack.
        if (w_rd) begin
            case (w_idx)
                c_reg_ctrl:     dat_d = {29'd0, ctrl_q};
                c_reg_prescale: dat_d = prescale_q;
                c_reg_time:     dat_d = w_time_word;
                c_reg_alarm:    dat_d = w_alarm_word;
                c_reg_status:   dat_d = {31'd0, flag_q};
                default:        dat_d = 32'd0;
            endcase
        end

        // Prescaler
        if (ctrl_q[0]) begin
            cnt_d = w_tick ? 32'd0 : cnt_q + 32'd1;
        end

        // Watch increment with full carry chain
        if (w_tick) begin
            chg_d = 1'b1;
            if (sec_q == c_sec_max) begin
                sec_d = 6'd0;
                if (min_q == c_min_max) begin
                    min_d  = 6'd0;
                    hour_d = (hour_q == c_hour_max) ? 5'd0 : hour_q + 5'd1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end

        // Register writes; placed after the tick so a TIME write overrides
        // the increment of a coincident tick.
        if (w_wr) begin
            case (w_idx)
                c_reg_ctrl: begin
                    ctrl_d = w_merged[2:0];
                end
                c_reg_prescale: begin
                    prescale_d = w_merged;
                    cnt_d      = 32'd0;
                end
                c_reg_time: begin
                    sec_d  = (w_merged[5:0]   > c_sec_max)  ? 6'd0 : w_merged[5:0];
                    min_d  = (w_merged[13:8]  > c_min_max)  ? 6'd0 : w_merged[13:8];
                    hour_d = (w_merged[20:16] > c_hour_max) ? 5'd0 : w_merged[20:16];
                    chg_d  = 1'b1;
                end
                c_reg_alarm: begin
                    asec_d  = (w_merged[5:0]   > c_sec_max)  ? 6'd0 : w_merged[5:0];
                    amin_d  = (w_merged[13:8]  > c_min_max)  ? 6'd0 : w_merged[13:8];
                    ahour_d = (w_merged[20:16] > c_hour_max) ? 5'd0 : w_merged[20:16];
                end
                default: begin
                end
            endcase
        end

        // Alarm flag: clear first so a simultaneous set takes priority.
        if (w_clr) begin
            flag_d = 1'b0;
        end
        if (chg_q && ctrl_q[1] && (w_time_word == w_alarm_word)) begin
            flag_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q      <= 1'b0;
            dat_q      <= 32'd0;
            tick_q     <= 1'b0;
            irq_q      <= 1'b0;
            ctrl_q     <= 3'd0;
            prescale_q <= PRESCALE_RST;
            cnt_q      <= 32'd0;
            sec_q      <= 6'd0;
            min_q      <= 6'd0;
            hour_q     <= 5'd0;
            asec_q     <= 6'd0;
            amin_q     <= 6'd0;
            ahour_q    <= 5'd0;
            flag_q     <= 1'b0;
            chg_q      <= 1'b0;
        end else begin
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            tick_q     <= tick_d;
            irq_q      <= irq_d;
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            cnt_q      <= cnt_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            asec_q     <= asec_d;
            amin_q     <= amin_d;
            ahour_q    <= ahour_d;
            flag_q     <= flag_d;
            chg_q      <= chg_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign tick_o    = tick_q;
    assign irq_o     = irq_q;

endmodule
`default_nettype wire

// File: doc/homegrown_watch_wb.md
HOMEGROWN_WATCH_WB -- requirements
Module: homegrown_watch_wb

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone base address of the 32-byte register window.
REQ-002 SHALL have parameter PRESCALE_RST, default 32'd9_999_999, reset value of PRESCALE register.
REQ-003 SHALL have port wb_clk_i  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port wb_rst_ni  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports wbs_stb_i, wbs_cyc_i, wbs_we_i  input  1 each  Wishbone classic strobe, cycle, write-enable.
REQ-006 SHALL have ports wbs_sel_i  input  4  byte lanes; wbs_adr_i  input  32  byte address; wbs_dat_i  input  32  write data.
REQ-007 SHALL have ports wbs_ack_o  output  1  acknowledge; wbs_dat_o  output  32  read data.
REQ-008 SHALL have port tick_o  output  1  one-cycle pulse per watch second.
REQ-009 SHALL have port irq_o  output  1  registered alarm interrupt.

Function
REQ-010 Register map (offset): 0x00 CTRL [0]=run,[1]=alarm_en,[2]=irq_en; 0x04 PRESCALE[31:0]; 0x08 TIME [5:0]=sec,[13:8]=min,[20:16]=hour; 0x0C ALARM same format; 0x10 STATUS [0]=alarm_flag (W1C); unused bits read 0.
REQ-011 Decode: request selected when wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:5] == BASE_ADDR[31:5]); unselected requests SHALL never be acked.
REQ-012 Selected request SHALL receive wbs_ack_o high exactly one cycle, in the cycle after the request is first seen; no new request accepted while wbs_ack_o is high (ack drops for >=1 cycle between transfers).
REQ-013 Read data SHALL be registered and valid in the ack cycle; offsets 0x14-0x1C read 0 and are acked; writes to them ignored.
REQ-014 Writes SHALL update only byte lanes with wbs_sel_i set; write takes effect in the ack cycle edge.
REQ-015 Prescaler counter SHALL increment each cycle while run=1, hold while run=0; when counter == PRESCALE it SHALL reset to 0 and pulse tick_o for one cycle; PRESCALE=0 gives tick every cycle.
REQ-016 Any write to PRESCALE SHALL clear the prescaler counter to 0.
REQ-017 On tick: sec+1; sec 59->0 carries min+1; min 59->0 carries hour+1; hour 23->0 (full wrap 23:59:59 -> 00:00:00).
REQ-018 TIME/ALARM write with field out of range (sec/min>59, hour>23) SHALL store 0 in that field.
REQ-019 TIME write coinciding with tick: write value SHALL win; that tick's increment is discarded; tick_o still pulses.
REQ-020 alarm_flag SHALL set in the cycle after TIME changes (tick or write) to a value equal to ALARM while alarm_en=1.
REQ-021 STATUS write with bit0=1 (lane 0 selected) SHALL clear alarm_flag; simultaneous set and clear: set wins.
REQ-022 irq_o SHALL equal registered (alarm_flag & irq_en), one cycle after either changes.

Reset
REQ-023 On wb_rst_ni low, asynchronously: wbs_ack_o=0, wbs_dat_o=0, tick_o=0, irq_o=0, CTRL=0, TIME=0, ALARM=0, alarm_flag=0, prescaler counter=0, PRESCALE=PRESCALE_RST.
REQ-024 Reset asserted mid-transfer SHALL abort it; no ack after release until a new request is presented.
REQ-025 Reset release SHALL be synchronous-safe: first active edge after deassertion behaves as normal operation.

Verification
REQ-026 Read 0x3000_0004 after reset -> ack one cycle later, data 32'd9_999_999; read 0x3000_0040 -> no ack for 16 cycles.
REQ-027 Write PRESCALE=3, TIME=0x0017_3B3B (23:59:59), CTRL=1 -> tick_o every 4 cycles; TIME reads 0x0000_0000 after first tick.
REQ-028 Write TIME with sel=4'b0001, data 0x0000_0005 over 0x0000_0A00 -> TIME reads 0x0000_0A05.
REQ-029 ALARM=0x0000_0002, CTRL=7, PRESCALE=0, TIME=0 -> alarm_flag set after 2nd tick, irq_o high next cycle; STATUS write 1 -> irq_o low.
REQ-030 Write TIME=0x0000_0010 in same cycle as tick -> TIME reads 0x0000_0010, tick_o pulsed.
REQ-031 Assert wb_rst_ni low during tick stream and pending read -> all outputs 0 immediately, PRESCALE reads default after release.
